// File: rtl/shift_register_serializer.sv
// Bidirectional shift register serializer.
// A word is loaded on start and shifted out one bit per enabled cycle, either
// LSB-first or MSB-first. serialIn fills the vacated end, so a transfer both
// transmits and receives one word. A start/busy/done handshake frames each word.
module shift_register_serializer #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   msbFirst,
    input  logic                   enable,
    input  logic                   serialIn,
    input  logic [WORD_LENGTH-1:0] parallelInput,
    output logic                   serialOutput,
    output logic [WORD_LENGTH-1:0] parallelOutput,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_WIDTH = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_LENGTH-1:0] shreg_q, shreg_d;
    logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
    logic                   dir_q,   dir_d;
    logic                   busy_q;
    logic                   done_q;

    // Next-state logic: load from IDLE/DONE, shift and count while enabled in SHIFT
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = parallelInput;
                    dir_d   = msbFirst;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    if (dir_q) begin
                        shreg_d = {shreg_q[WORD_LENGTH-2:0], serialIn};
                    end else begin
                        shreg_d = {serialIn, shreg_q[WORD_LENGTH-1:1]};
                    end
                    if (cnt_q == LAST_CNT) begin
                        // Clearing here keeps the counter inside 0..WORD_LENGTH-1
                        // even when WORD_LENGTH is not a power of two.
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (start) begin
                    shreg_d = parallelInput;
                    dir_d   = msbFirst;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; busy/done are registered decodes of the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= (state_d == SHIFT);
            done_q  <= (state_d == DONE);
        end
    end

    assign serialOutput   = dir_q ? shreg_q[WORD_LENGTH-1] : shreg_q[0];
    assign parallelOutput = shreg_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_shift_register_serializer.sv
// Testbench for shift_register_serializer (WORD_LENGTH = 8).
module tb_shift_register_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       msbFirst;
    logic       enable;
    logic       serialIn;
    logic [7:0] parallelInput;
    logic       serialOutput;
    logic [7:0] parallelOutput;
    logic       busy;
    logic       done;

    shift_register_serializer #(.WORD_LENGTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .msbFirst       (msbFirst),
        .enable         (enable),
        .serialIn       (serialIn),
        .parallelInput  (parallelInput),
        .serialOutput   (serialOutput),
        .parallelOutput (parallelOutput),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       msb;
        logic       sin;
        logic       loopback;
        logic       toggle;
        logic [7:0] final_exp;
    } vec_t;

    vec_t vecs [6];
    logic q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bits(input logic [7:0] d, input logic msb);
        for (int i = 0; i < 8; i++) begin
            q.push_back(msb ? d[7-i] : d[i]);
        end
    endtask

    task automatic chk_bit(input string name);
        if (q.size() == 0) begin
            chk({name, "_underflow"}, 32'd1, 32'd0);
        end else begin
            chk(name, {31'd0, serialOutput}, {31'd0, q[0]});
        end
    endtask

    task automatic run_word(input vec_t v);
        logic [7:0] m;
        logic       en;
        int         cyc;
        int         nb;
        int         nd;
        @(negedge clk);
        start = 1'b1; parallelInput = v.data; msbFirst = v.msb;
        enable = 1'b1; serialIn = v.sin;
        push_bits(v.data, v.msb);
        m = v.data;
        @(negedge clk);
        start = 1'b0; parallelInput = 8'($urandom); msbFirst = ~v.msb;
        nb = 0; nd = 0; cyc = 0;
        while (cyc < 64) begin
            if (busy) begin
                nb++;
                en = v.toggle ? (cyc % 2 == 0) : 1'b1;
                enable = en;
                if (v.loopback) serialIn = serialOutput;
                chk("par_shift", {24'd0, parallelOutput}, {24'd0, m});
                chk_bit("ser_bit");
                if (en) begin
                    if (q.size() > 0) void'(q.pop_front());
                    m = v.msb ? {m[6:0], serialIn} : {serialIn, m[7:1]};
                end
            end else if (done) begin
                nd++;
                chk("final_par", {24'd0, parallelOutput}, {24'd0, v.final_exp});
            end else begin
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 64) chk("word_timeout", 32'd1, 32'd0);
        chk("busy_cycles", nb, v.toggle ? 32'd15 : 32'd8);
        chk("done_pulses", nd, 32'd1);
        chk("queue_empty", q.size(), 32'd0);
        enable = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;
        int         cyc;
        int         nb;

        vecs[0] = '{data: 8'h1E, msb: 1'b0, sin: 1'b0, loopback: 1'b0, toggle: 1'b0, final_exp: 8'h00};
        vecs[1] = '{data: 8'h1E, msb: 1'b1, sin: 1'b0, loopback: 1'b0, toggle: 1'b0, final_exp: 8'h00};
        vecs[2] = '{data: 8'hB4, msb: 1'b0, sin: 1'b0, loopback: 1'b1, toggle: 1'b0, final_exp: 8'hB4};
        vecs[3] = '{data: 8'hFF, msb: 1'b0, sin: 1'b0, loopback: 1'b0, toggle: 1'b1, final_exp: 8'h00};
        vecs[4] = '{data: 8'h3C, msb: 1'b1, sin: 1'b1, loopback: 1'b0, toggle: 1'b0, final_exp: 8'hFF};
        vecs[5] = '{data: 8'hA5, msb: 1'b1, sin: 1'b0, loopback: 1'b1, toggle: 1'b0, final_exp: 8'hA5};

        reset = 1'b0; start = 1'b0; msbFirst = 1'b0; enable = 1'b0;
        serialIn = 1'b0; parallelInput = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ser",  {31'd0, serialOutput}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_par",  {24'd0, parallelOutput}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_word(vecs[i]);
        end

        // start held through SHIFT, then back-to-back reload from DONE
        @(negedge clk);
        start = 1'b1; parallelInput = 8'hA5; msbFirst = 1'b0; enable = 1'b1; serialIn = 1'b0;
        push_bits(8'hA5, 1'b0);
        m = 8'hA5;
        @(negedge clk);
        cyc = 0; nb = 0;
        while (busy && cyc < 64) begin
            nb++;
            parallelInput = 8'($urandom); msbFirst = 1'($urandom);
            chk("hold_par", {24'd0, parallelOutput}, {24'd0, m});
            chk_bit("hold_ser");
            if (q.size() > 0) void'(q.pop_front());
            m = {1'b0, m[7:1]};
            @(negedge clk);
            cyc++;
        end
        chk("hold_busy_cycles", nb, 32'd8);
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_final", {24'd0, parallelOutput}, 32'h00);
        parallelInput = 8'h0F; msbFirst = 1'b0;
        push_bits(8'h0F, 1'b0);
        m = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_done", {31'd0, done}, 32'd0);
        cyc = 0; nb = 0;
        while (busy && cyc < 64) begin
            nb++;
            chk("b2b_par", {24'd0, parallelOutput}, {24'd0, m});
            chk_bit("b2b_ser");
            if (q.size() > 0) void'(q.pop_front());
            m = {1'b0, m[7:1]};
            @(negedge clk);
            cyc++;
        end
        chk("b2b_busy_cycles", nb, 32'd8);
        chk("b2b_done_end", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("b2b_idle", {30'd0, busy, done}, 32'd0);

        // asynchronous reset in the middle of a transfer
        start = 1'b1; parallelInput = 8'hFF; msbFirst = 1'b0; enable = 1'b1; serialIn = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_par", {24'd0, parallelOutput}, 32'h1F);
        chk("mid_ser", {31'd0, serialOutput}, 32'd1);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_ser",  {31'd0, serialOutput}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_par",  {24'd0, parallelOutput}, 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
        run_word(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
